data_memory_sized: RTL and testbench

//  Single-port data memory for the ARM7 core with a valid/ready request channel and a one-cycle response.

---
 rtl/data_memory_sized.sv | 205 ++++++++++++++++++++
 tb/tb_data_memory_sized.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// ----------------------------------------------------------------------------
// data_memory_sized
//   Single-port data memory for the ARM7 load/store unit. A valid/ready
//   request channel accepts one access at a time; the access is performed
//   after an optional number of wait states and answered with a single-cycle
//   response carrying extended load data or a fault flag.
//
// Parameters
//   DEPTH_LOG2   log2 of memory depth in 32-bit words
//   WAIT_STATES  extra cycles between request accept and the access (0..15)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request (IDLE and out of reset)
//   req_write   1 = store, 0 = load
//   req_size    00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed  loads only: sign-extend byte/halfword
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   rsp_valid   one-cycle response strobe per accepted request
//   rsp_rdata   extended load data; 0 for stores and faults
//   rsp_fault   access rejected, qualified by rsp_valid
// ----------------------------------------------------------------------------
module data_memory_sized #(
    parameter int DEPTH_LOG2  = 18,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic        accept;

    // Request captured at the accept edge
    logic        op_write;
    logic [1:0]  op_size;
    logic        op_signed;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;

    // Storage, one packed word of four byte lanes per entry
    logic [3:0][7:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           rd_word;
    logic [7:0]            byte_val;
    logic [15:0]           half_val;
    logic                  fault;
    logic [3:0]            byte_en;
    logic [31:0]           lane_wdata;
    logic [31:0]           load_data;

    assign req_ready = (state == ST_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign word_idx  = op_addr[DEPTH_LOG2+1:2];
    assign rd_word   = mem[word_idx];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = CNT_INIT;
                    end else begin
                        state_nx = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nx = ST_RESP;
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Access decode: fault detection, lane enables, load extraction
    // ------------------------------------------------------------------
    always_comb begin
        fault      = 1'b0;
        byte_en    = 4'b0000;
        lane_wdata = op_wdata;
        load_data  = '0;
        byte_val   = 8'(rd_word >> {op_addr[1:0], 3'b000});
        half_val   = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (op_size)
            2'b00: begin
                byte_en    = 4'b0001 << op_addr[1:0];
                lane_wdata = {4{op_wdata[7:0]}};
                load_data  = {{24{op_signed & byte_val[7]}}, byte_val};
            end
            2'b01: begin
                fault      = op_addr[0];
                byte_en    = op_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{op_wdata[15:0]}};
                load_data  = {{16{op_signed & half_val[15]}}, half_val};
            end
            2'b10: begin
                fault     = (op_addr[1:0] != 2'b00);
                byte_en   = 4'b1111;
                load_data = rd_word;
            end
            default: fault = 1'b1;
        endcase

        // Any address bit above the implemented range rejects the access
        if ((op_addr >> (DEPTH_LOG2 + 2)) != 32'd0) begin
            fault = 1'b1;
        end

        if (fault) begin
            byte_en = 4'b0000;
        end
        if (fault || op_write) begin
            load_data = '0;
        end
    end

    // ------------------------------------------------------------------
    // State, request capture and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_write  <= 1'b0;
            op_size   <= '0;
            op_signed <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                op_write  <= req_write;
                op_size   <= req_size;
                op_signed <= req_signed;
                op_addr   <= req_addr;
                op_wdata  <= req_wdata;
            end
            rsp_valid <= (state == ST_ACCESS);
            rsp_rdata <= (state == ST_ACCESS) ? load_data : '0;
            rsp_fault <= (state == ST_ACCESS) && fault;
        end
    end

    // ------------------------------------------------------------------
    // Byte-lane writes. Reset is in the sensitivity list only so that a
    // reset coincident with the ACCESS edge suppresses the store; the
    // contents themselves are never cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if ((state == ST_ACCESS) && op_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i[1:0]] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
module tb_data_memory_sized;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n, rst2_n, v0, v2;
    logic        wr, sg;
    logic [1:0]  sz;
    logic [31:0] ad, wd;
    logic        rdy0, rdy2, rv0, rv2, f0, f2;
    logic [31:0] rd0, rd2;

    int errors = 0;
    int checks = 0;

    // Reference memory: byte-addressed, keyed per instance
    bit [7:0] mdl [int unsigned];

    data_memory_sized #(.DEPTH_LOG2(18), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .req_valid(v0), .req_ready(rdy0),
        .req_write(wr), .req_size(sz), .req_signed(sg), .req_addr(ad),
        .req_wdata(wd), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(f0)
    );

    data_memory_sized #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .req_valid(v2), .req_ready(rdy2),
        .req_write(wr), .req_size(sz), .req_signed(sg), .req_addr(ad),
        .req_wdata(wd), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_fault(f2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int unsigned key(input int sel, input logic [31:0] a);
        return sel != 0 ? a + 32'h8000_0000 : a;
    endfunction

    function automatic bit model_fault(input int sel, input logic [31:0] a, input logic [1:0] s);
        longint unsigned limit;
        limit = longint'(1) << ((sel != 0 ? 10 : 18) + 2);
        return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) ||
               (s == 2'd2 && a % 4 != 0) || (longint'(a) >= limit);
    endfunction

    function automatic logic [31:0] model_load(input int sel, input logic [31:0] a,
                                               input logic [1:0] s, input bit sgn);
        bit [7:0]  b;
        bit [15:0] h;
        case (s)
            2'd0: begin
                b = mdl[key(sel, a)];
                return sgn ? int'($signed(b)) : {24'd0, b};
            end
            2'd1: begin
                h = {mdl[key(sel, a + 1)], mdl[key(sel, a)]};
                return sgn ? int'($signed(h)) : {16'd0, h};
            end
            default:
                return {mdl[key(sel, a + 3)], mdl[key(sel, a + 2)],
                        mdl[key(sel, a + 1)], mdl[key(sel, a)]};
        endcase
    endfunction

    task automatic do_op(input int sel, input bit w, input logic [1:0] s, input bit sgn,
                         input logic [31:0] a, input logic [31:0] d, input string tag,
                         output logic [31:0] r);
        bit          exp_f;
        logic [31:0] exp_r;
        int          lat;
        int          nb;
        bit          early_ready;
        exp_f = model_fault(sel, a, s);
        exp_r = (w || exp_f) ? 32'd0 : model_load(sel, a, s, sgn);
        nb    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;

        @(negedge clk);
        check({tag, ".ready_idle"}, sel != 0 ? rdy2 : rdy0, 1'b1);
        wr = w; sz = s; sg = sgn; ad = a; wd = d;
        if (sel != 0) v2 = 1'b1; else v0 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0; v2 = 1'b0;
        // Garbage on the request bus must not affect the captured operation
        wr = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom);
        ad = $urandom; wd = $urandom;

        lat = 0;
        early_ready = 1'b0;
        r = 32'd0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if ((sel != 0 ? rdy2 : rdy0) === 1'b1) early_ready = 1'b1;
            if ((sel != 0 ? rv2 : rv0) === 1'b1) break;
        end
        r = sel != 0 ? rd2 : rd0;
        check({tag, ".latency"}, lat, (sel != 0) ? 4 : 2);
        check({tag, ".busy"}, early_ready, 1'b0);
        check({tag, ".rdata"}, r, exp_r);
        check({tag, ".fault"}, sel != 0 ? f2 : f0, exp_f);
        @(negedge clk);
        check({tag, ".one_shot"}, sel != 0 ? rv2 : rv0, 1'b0);
        check({tag, ".ready_again"}, sel != 0 ? rdy2 : rdy0, 1'b1);

        if (w && !exp_f) begin
            for (int i = 0; i < nb; i++) mdl[key(sel, a + i)] = 8'(d >> (8 * i));
        end
    endtask

    task automatic rst_mid(input int sel, input logic [31:0] a, input logic [31:0] d,
                           input string tag);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        wr = 1'b1; sz = 2'd0; sg = 1'b0; ad = a; wd = d;
        if (sel != 0) v2 = 1'b1; else v0 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0; v2 = 1'b0;
        @(negedge clk);
        if ((sel != 0 ? rv2 : rv0) === 1'b1) seen = 1'b1;
        // Request is now in WAIT (2 wait states) or ACCESS (no wait states)
        if (sel != 0) rst2_n = 1'b0; else rst0_n = 1'b0;
        #1;
        check({tag, ".rst_ready"}, sel != 0 ? rdy2 : rdy0, 1'b0);
        check({tag, ".rst_valid"}, sel != 0 ? rv2 : rv0, 1'b0);
        check({tag, ".rst_rdata"}, sel != 0 ? rd2 : rd0, 32'd0);
        check({tag, ".rst_fault"}, sel != 0 ? f2 : f0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            if ((sel != 0 ? rv2 : rv0) === 1'b1) seen = 1'b1;
        end
        if (sel != 0) rst2_n = 1'b1; else rst0_n = 1'b1;
        @(negedge clk);
        check({tag, ".ready_after"}, sel != 0 ? rdy2 : rdy0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            if ((sel != 0 ? rv2 : rv0) === 1'b1) seen = 1'b1;
        end
        check({tag, ".no_rsp"}, seen, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          sel;
        int          dl;

        rst0_n = 1'b0; rst2_n = 1'b0; v0 = 1'b0; v2 = 1'b0;
        wr = 1'b0; sz = 2'd0; sg = 1'b0; ad = '0; wd = '0;
        repeat (3) @(negedge clk);
        check("reset.ready0", rdy0, 1'b0);
        check("reset.valid0", rv0, 1'b0);
        check("reset.rdata0", rd0, 32'd0);
        check("reset.fault0", f0, 1'b0);
        check("reset.ready2", rdy2, 1'b0);
        check("reset.valid2", rv2, 1'b0);
        rst0_n = 1'b1; rst2_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = s * 2;
            do_op(sel, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, "t1.st", r);
            do_op(sel, 0, 2'd2, 0, 32'h100, 32'h0, "t1.ld", r);
            check("t1.word", r, 32'hDEADBEEF);
            do_op(sel, 1, 2'd0, 0, 32'h101, 32'h123456AA, "t2.stb", r);
            do_op(sel, 0, 2'd2, 0, 32'h100, 32'h0, "t2.ldw", r);
            check("t2.word", r, 32'hDEADAAEF);
            do_op(sel, 0, 2'd0, 1, 32'h101, 32'h0, "t2.ldsb", r);
            check("t2.sbyte", r, 32'hFFFFFFAA);
            do_op(sel, 0, 2'd0, 0, 32'h101, 32'h0, "t2.ldub", r);
            check("t2.ubyte", r, 32'h000000AA);
            do_op(sel, 0, 2'd1, 1, 32'h102, 32'h0, "t3.ldsh", r);
            check("t3.shalf", r, 32'hFFFFDEAD);
            do_op(sel, 0, 2'd1, 0, 32'h102, 32'h0, "t3.lduh", r);
            check("t3.uhalf", r, 32'h0000DEAD);
            do_op(sel, 1, 2'd1, 0, 32'h102, 32'hFFFF1234, "t3.sth", r);
            do_op(sel, 0, 2'd2, 0, 32'h100, 32'h0, "t3.ldw", r);
            check("t3.word", r, 32'h1234AAEF);
            do_op(sel, 1, 2'd2, 0, 32'h102, 32'h01020304, "t4.st_mis", r);
            do_op(sel, 0, 2'd1, 0, 32'h101, 32'h0, "t4.ld_mis", r);
            do_op(sel, 0, 2'd3, 0, 32'h100, 32'h0, "t4.size3", r);
            do_op(sel, 1, 2'd2, 0, sel != 0 ? 32'h1000 : 32'h0010_0000, 32'hCAFEF00D, "t4.range", r);
            do_op(sel, 0, 2'd2, 0, 32'h100, 32'h0, "t4.ldw", r);
            check("t4.word", r, 32'h1234AAEF);

            do_op(sel, 1, 2'd2, 0, 32'h200, 32'h11223344, "t6.init", r);
            rst_mid(sel, 32'h200, 32'h55, "t6");
            do_op(sel, 0, 2'd2, 0, 32'h200, 32'h0, "t6.ld", r);
            check("t6.word", r, 32'h11223344);
        end

        for (int s = 0; s < 2; s++) begin
            sel = s * 2;
            dl  = (sel != 0) ? 10 : 18;
            for (int i = 0; i < 16; i++)
                do_op(sel, 1, 2'd2, 0, 32'h400 + 32'(4 * i), $urandom, "rnd.init", r);
            for (int i = 0; i < 120; i++) begin
                a = 32'h400 + $urandom_range(0, 63);
                if ($urandom_range(0, 15) == 0)
                    a = a | (32'h1 << $urandom_range(dl + 2, 31));
                do_op(sel, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, "rnd", r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
